// File: rtl/mips_multicycle_ctrl_if.sv
// ALU operation interface between the multi-cycle control FSM and the
// shared ALU.
//   master (controller): drives aluoperation, alu_src_a, alu_src_b;
//                        samples branch and zero.
//   slave  (ALU side)  : the mirror image.
// The 3-bit operation codes are ADD=010, SUB=110, AND=000, OR=001,
// SLT=111, BNE=011 and BEQ=101.
interface mips_multicycle_ctrl_if;
  logic [2:0] aluoperation;
  logic       alu_src_a;   // 0=PC, 1=regA
  logic [1:0] alu_src_b;   // 00=regB, 01=4, 10=imm, 11=imm<<2
  logic       branch;      // branch-taken flag, meaningful in BRANCH only
  logic       zero;        // informational, not used for control

  modport master (output aluoperation, alu_src_a, alu_src_b,
                  input  branch, zero);
  modport slave  (input  aluoperation, alu_src_a, alu_src_b,
                  output branch, zero);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM.
// It sequences fetch, decode, execute, memory and write-back, and drives
// the datapath enables and multiplexer selects.
//   clk, rst      : clock, and a synchronous active-high reset
//   opcode, funct : instruction-register fields
//   alu           : ALU operation interface (master side)
//   pc_source, pc_write, ir_write, iord, mem_read, mem_write,
//   reg_write, reg_dst, mem_to_reg : datapath controls
//   state         : current state code (debug)
//   illegal       : high while in TRAP
//   instr_count   : retired-instruction counter
module mips_multicycle_ctrl #(
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned COUNT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  mips_multicycle_ctrl_if.master alu,
  output logic [1:0]             pc_source,
  output logic                   pc_write,
  output logic                   ir_write,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic [3:0]             state,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPE_EX = 4'd6, S_ALU_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ITYPE_EX = 4'd10, S_ITYPE_WB = 4'd11,
    S_TRAP = 4'd12
  } state_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101,
                         OP_ADDI  = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI   = 6'b001101, OP_LW   = 6'b100011,
                         OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010,
                         FN_AND = 6'b100100, FN_OR  = 6'b100101,
                         FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110,
                         ALU_AND = 3'b000, ALU_OR  = 3'b001,
                         ALU_SLT = 3'b111, ALU_BNE = 3'b011,
                         ALU_BEQ = 3'b101;

  state_t                 state_q, state_d;
  ctrl_t                  ctrl, ctrl_out;
  logic                   retire;
  logic [COUNT_WIDTH-1:0] count_q;

  // NOTE: every variable written here gets a default before the case, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = S_FETCH;
    ctrl      = '0;
    ctrl.aluop = ALU_ADD;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = 1'b1;
        ctrl.src_b    = 2'b01;
        ctrl.pc_write = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        ctrl.src_b = 2'b11;  // branch target into ALUOut ahead of BRANCH
        case (opcode)
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_RTYPE:                state_d = S_RTYPE_EX;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_ITYPE_EX;
          default:                 state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.src_a = 1'b1;
        ctrl.src_b = 2'b10;
        state_d    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        retire         = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.src_a = 1'b1;
        state_d    = S_ALU_WB;
        case (funct)
          FN_ADD:  ctrl.aluop = ALU_ADD;
          FN_SUB:  ctrl.aluop = ALU_SUB;
          FN_AND:  ctrl.aluop = ALU_AND;
          FN_OR:   ctrl.aluop = ALU_OR;
          FN_SLT:  ctrl.aluop = ALU_SLT;
          default: state_d    = S_TRAP;
        endcase
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire         = 1'b1;
      end
      S_BRANCH: begin
        ctrl.src_a     = 1'b1;
        ctrl.pc_source = 2'b01;
        ctrl.aluop     = (opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
        ctrl.pc_write  = alu.branch;
        retire         = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_write  = 1'b1;
        retire         = 1'b1;
      end
      S_ITYPE_EX: begin
        ctrl.src_a = 1'b1;
        ctrl.src_b = 2'b10;
        state_d    = S_ITYPE_WB;
        case (opcode)
          OP_ANDI: ctrl.aluop = ALU_AND;
          OP_ORI:  ctrl.aluop = ALU_OR;
          default: ctrl.aluop = ALU_ADD;
        endcase
      end
      S_ITYPE_WB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
        state_d      = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      end
      default: ctrl.aluop = 3'b000;  // codes 13-15: recover quietly
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  // Reset takes effect on the outputs at once, so an instruction that is
  // aborted mid-flight issues no further writes, even in the reset cycle.
  assign ctrl_out         = rst ? '0 : ctrl;
  assign alu.aluoperation = ctrl_out.aluop;
  assign alu.alu_src_a    = ctrl_out.src_a;
  assign alu.alu_src_b    = ctrl_out.src_b;
  assign pc_source        = ctrl_out.pc_source;
  assign pc_write         = ctrl_out.pc_write;
  assign ir_write         = ctrl_out.ir_write;
  assign iord             = ctrl_out.iord;
  assign mem_read         = ctrl_out.mem_read;
  assign mem_write        = ctrl_out.mem_write;
  assign reg_write        = ctrl_out.reg_write;
  assign reg_dst          = ctrl_out.reg_dst;
  assign mem_to_reg       = ctrl_out.mem_to_reg;
  assign illegal          = ctrl_out.illegal;
  assign state            = rst ? 4'd0 : state_q;
  assign instr_count      = rst ? '0 : count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BAD = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       branch = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;

  // DUT 1: sticky trap
  mips_multicycle_ctrl_if alu1 ();
  logic [1:0]  pc_source1;
  logic        pc_write1, ir_write1, iord1, mem_read1, mem_write1;
  logic        reg_write1, reg_dst1, mem_to_reg1, illegal1;
  logic [3:0]  state1;
  logic [31:0] count1;
  assign alu1.branch = branch;
  assign alu1.zero   = 1'b0;

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1), .COUNT_WIDTH(32)) u_dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu(alu1),
    .pc_source(pc_source1), .pc_write(pc_write1), .ir_write(ir_write1),
    .iord(iord1), .mem_read(mem_read1), .mem_write(mem_write1),
    .reg_write(reg_write1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
    .state(state1), .illegal(illegal1), .instr_count(count1)
  );

  // DUT 2: one-cycle illegal pulse
  mips_multicycle_ctrl_if alu2 ();
  logic [1:0]  pc_source2;
  logic        pc_write2, ir_write2, iord2, mem_read2, mem_write2;
  logic        reg_write2, reg_dst2, mem_to_reg2, illegal2;
  logic [3:0]  state2;
  logic [31:0] count2;
  assign alu2.branch = branch;
  assign alu2.zero   = 1'b1;

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0), .COUNT_WIDTH(32)) u_dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu(alu2),
    .pc_source(pc_source2), .pc_write(pc_write2), .ir_write(ir_write2),
    .iord(iord2), .mem_read(mem_read2), .mem_write(mem_write2),
    .reg_write(reg_write2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
    .state(state2), .illegal(illegal2), .instr_count(count2)
  );

  // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
  //  mem_to_reg, src_a, src_b[1:0], pc_source[1:0], aluop[2:0], illegal}
  logic [16:0] ctrl1;
  assign ctrl1 = {pc_write1, ir_write1, iord1, mem_read1, mem_write1,
                  reg_write1, reg_dst1, mem_to_reg1, alu1.alu_src_a,
                  alu1.alu_src_b, pc_source1, alu1.aluoperation, illegal1};

  function automatic logic [16:0] cv(input logic pw, irw, io, mr, mw, rw,
                                     rd, m2r, sa, input logic [1:0] sb, ps,
                                     input logic [2:0] op, input logic ill);
    return {pw, irw, io, mr, mw, rw, rd, m2r, sa, sb, ps, op, ill};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic        br;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] cnt;
    bit          chk2;
    logic [3:0]  st2;
    logic        ill2;
    bit [63:0]   tag;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] exp_count = 0;
  int          total = 0;
  int          bad = 0;

  task automatic push(input logic r, input logic [5:0] o, f, input logic b,
                      input logic [3:0] s, input logic [16:0] c,
                      input bit [63:0] t, input bit k2 = 1'b0,
                      input logic [3:0] s2 = 4'd0, input logic i2 = 1'b0);
    ent_t e;
    e.rst = r; e.opc = o; e.fn = f; e.br = b; e.st = s; e.ctrl = c;
    e.cnt = exp_count; e.chk2 = k2; e.st2 = s2; e.ill2 = i2; e.tag = t;
    sb.push_back(e);
  endtask

  task automatic push_fetch(input logic [5:0] o, f, input logic b, input bit [63:0] t);
    push(0, o, f, b, 4'd0, cv(1,1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0), t);
  endtask

  // Expected cycle-by-cycle outputs for one instruction, from the
  // state table; the count advances once the instruction retires.
  task automatic push_instr(input logic [5:0] o, f, input logic b, input bit [63:0] t);
    logic [2:0] op;
    bit         ok;
    ok = 1'b1;
    push_fetch(o, f, b, t);
    push(0, o, f, b, 4'd1, cv(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), t);
    case (o)
      OP_LW, OP_SW: begin
        push(0, o, f, b, 4'd2, cv(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), t);
        if (o == OP_LW) begin
          push(0, o, f, b, 4'd3, cv(0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010,0), t);
          push(0, o, f, b, 4'd4, cv(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0), t);
        end else begin
          push(0, o, f, b, 4'd5, cv(0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b010,0), t);
        end
      end
      OP_R: begin
        case (f)
          6'b100000: op = 3'b010;
          6'b100010: op = 3'b110;
          6'b100100: op = 3'b000;
          6'b100101: op = 3'b001;
          default:   op = 3'b111;
        endcase
        push(0, o, f, b, 4'd6, cv(0,0,0,0,0,0,0,0,1,2'b00,2'b00,op,0), t);
        push(0, o, f, b, 4'd7, cv(0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b010,0), t);
      end
      OP_BEQ, OP_BNE: begin
        op = (o == OP_BEQ) ? 3'b101 : 3'b011;
        push(0, o, f, b, 4'd8, cv(b,0,0,0,0,0,0,0,1,2'b00,2'b01,op,0), t);
      end
      OP_J:
        push(0, o, f, b, 4'd9, cv(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0), t);
      OP_ADDI, OP_ANDI, OP_ORI: begin
        op = (o == OP_ANDI) ? 3'b000 : (o == OP_ORI) ? 3'b001 : 3'b010;
        push(0, o, f, b, 4'd10, cv(0,0,0,0,0,0,0,0,1,2'b10,2'b00,op,0), t);
        push(0, o, f, b, 4'd11, cv(0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0), t);
      end
      default: begin
        ok = 1'b0;
        push(0, o, f, b, 4'd12, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,1), t);
      end
    endcase
    if (ok) exp_count = exp_count + 1;
  endtask

  task automatic push_reset(input int n, input bit [63:0] t);
    exp_count = 0;
    for (int i = 0; i < n; i++)
      push(1, OP_R, 6'd0, 0, 4'd0, 17'd0, t, 1'b1, 4'd0, 1'b0);
  endtask

  // Drives each entry after a rising edge and compares on the falling edge.
  task automatic run_sb();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.rst; opcode = e.opc; funct = e.fn; branch = e.br;
      @(negedge clk);
      total++;
      if (state1 !== e.st) begin
        bad++;
        $display("FAIL %0s state: got %0d want %0d", e.tag, state1, e.st);
      end
      total++;
      if (ctrl1 !== e.ctrl) begin
        bad++;
        $display("FAIL %0s ctrl (st %0d): got %b want %b", e.tag, e.st, ctrl1, e.ctrl);
      end
      total++;
      if (count1 !== e.cnt) begin
        bad++;
        $display("FAIL %0s instr_count: got %0d want %0d", e.tag, count1, e.cnt);
      end
      if (e.chk2) begin
        total++;
        if (state2 !== e.st2 || illegal2 !== e.ill2 || count2 !== e.cnt) begin
          bad++;
          $display("FAIL %0s dut2 state/illegal/count: got %0d/%b/%0d want %0d/%b/%0d",
                   e.tag, state2, illegal2, count2, e.st2, e.ill2, e.cnt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    push_reset(2, "reset");
    run_sb();
  endtask

  task automatic test_lw();
    push_instr(OP_LW, 6'd0, 0, "lw");
    run_sb();
  endtask

  task automatic test_rtype();
    push_instr(OP_R, 6'b100010, 1, "sub");  // stale branch flag
    push_instr(OP_R, 6'b101010, 0, "slt");
    run_sb();
  endtask

  task automatic test_branch();
    push_instr(OP_BEQ, 6'd0, 1, "beq_t");
    push_instr(OP_BEQ, 6'd0, 0, "beq_nt");
    push_instr(OP_BNE, 6'd0, 1, "bne");
    run_sb();
  endtask

  task automatic test_jump_sw();
    push_instr(OP_J, 6'd0, 1, "j");
    push_instr(OP_SW, 6'd0, 1, "sw");
    run_sb();
  endtask

  task automatic test_back_to_back();
    push_instr(OP_ADDI, 6'd0, 0, "addi");
    push_instr(OP_ANDI, 6'd0, 1, "andi");
    push_instr(OP_ORI, 6'd0, 0, "ori");
    push_instr(OP_R, 6'b100000, 0, "add");
    push_instr(OP_R, 6'b100100, 1, "and");
    push_instr(OP_R, 6'b100101, 0, "or");
    push_instr(OP_LW, 6'd0, 1, "lw2");
    run_sb();
  endtask

  // The sticky DUT stays in TRAP; the pulsing DUT cycles FETCH, DECODE,
  // TRAP on the same illegal opcode.  Neither retires anything.
  task automatic test_trap();
    logic [3:0] s2;
    for (int i = 0; i < 12; i++) begin
      s2 = (i % 3 == 0) ? 4'd0 : (i % 3 == 1) ? 4'd1 : 4'd12;
      if (i == 0)
        push(0, OP_BAD, 6'd0, 0, 4'd0, cv(1,1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0),
             "trap", 1'b1, s2, 1'b0);
      else if (i == 1)
        push(0, OP_BAD, 6'd0, 0, 4'd1, cv(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0),
             "trap", 1'b1, s2, 1'b0);
      else
        push(0, OP_BAD, 6'd0, 0, 4'd12, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,1),
             "trap", 1'b1, s2, (s2 == 4'd12));
    end
    push_reset(2, "trap_rst");
    run_sb();
  endtask

  task automatic test_reset_abort();
    push_instr(OP_J, 6'd0, 0, "pre_j");
    push_fetch(OP_LW, 6'd0, 0, "abort");
    push(0, OP_LW, 6'd0, 0, 4'd1, cv(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), "abort");
    push(0, OP_LW, 6'd0, 0, 4'd2, cv(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), "abort");
    push_reset(3, "abort_rst");  // raised in what would be MEMRD
    push_instr(OP_LW, 6'd0, 0, "post_lw");
    push_fetch(OP_R, 6'b100000, 0, "final");
    run_sb();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_jump_sw();
    test_back_to_back();
    test_trap();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM; the initiating side of the ALU operation interface.
- Sequences fetch/decode/execute/memory/writeback and drives the 3-bit aluoperation code each cycle.
- Consumes the ALU branch/zero flags to resolve BEQ/BNE.
- Sits between the instruction register (opcode/funct) and the shared datapath: PC, memory, register file and a single ALU.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: illegal opcode/funct enters sticky TRAP state; 0: illegal pulses for one cycle and returns to FETCH.
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; stable after DECODE.
- funct  input  6  IR[5:0].
- branch  input  1  ALU branch flag; valid in the BRANCH state.
- zero  input  1  ALU zero flag; informational only, not used for control.
- aluoperation  output  3  ADD=010, SUB=110, AND=000, OR=001, SLT=111, BNE=011, BEQ=101.
- alu_src_a  output  1  0=PC, 1=regA.
- alu_src_b  output  2  00=regB, 01=const 4, 10=imm ext, 11=sign-ext imm<<2.
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- pc_write  output  1  PC load enable.
- ir_write  output  1  IR load enable.
- iord  output  1  memory address: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  destination: 0=rt, 1=rd.
- mem_to_reg  output  1  write-back source: 0=ALUOut, 1=MDR.
- state  output  4  current state code, for debug.
- illegal  output  1  illegal instruction indicator.
- instr_count  output  COUNT_WIDTH  retired instructions.

Behaviour:
- Moore outputs decoded from the registered state. Exceptions: aluoperation in RTYPE_EX and ITYPE_EX also depends on funct/opcode; pc_write in BRANCH equals the branch input.
- Control outputs not listed for a state are 0; aluoperation defaults to 010.
- While rst=1: state=FETCH(0), instr_count=0, illegal=0, all control outputs forced to 0.
- The first FETCH control cycle is the first cycle after rst deasserts. Reset mid-instruction aborts it with no further writes.
- FETCH(0): mem_read=1, ir_write=1, iord=0, src_a=0, src_b=01, aluop=010, pc_source=00, pc_write=1. Next: DECODE.
- DECODE(1): src_a=0, src_b=11, aluop=010 (branch target into ALUOut). Next by opcode:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 -> RTYPE_EX
  - 000100 beq / 000101 bne -> BRANCH
  - 000010 j -> JUMP
  - 001000 addi / 001100 andi / 001101 ori -> ITYPE_EX
  - any other opcode -> TRAP
- MEMADR(2): src_a=1, src_b=10, aluop=010. Next: MEMRD for lw, MEMWR for sw.
- MEMRD(3): mem_read=1, iord=1. Next: MEMWB.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEMWR(5): mem_write=1, iord=1. Next: FETCH.
- RTYPE_EX(6): src_a=1, src_b=00. aluop from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Next: ALU_WB; unknown funct -> TRAP.
- ALU_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH(8): src_a=1, src_b=00, pc_source=01, aluop=101 (beq) or 011 (bne), pc_write=branch. Next: FETCH.
- JUMP(9): pc_source=10, pc_write=1. Next: FETCH.
- ITYPE_EX(10): src_a=1, src_b=10, aluop 010/000/001 for addi/andi/ori. Next: ITYPE_WB.
- ITYPE_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- TRAP(12):
  - All enables 0, illegal=1.
  - TRAP_ON_ILLEGAL=1: remains in TRAP until rst.
  - TRAP_ON_ILLEGAL=0: one cycle in TRAP, then FETCH.
  - instr_count is not incremented for illegal instructions.
- Codes 13-15 are unreachable; if entered, next state is FETCH with all outputs 0.
- Latency in cycles: lw 5, sw 4, R-type 4, I-type ALU 4, beq/bne 3, j 3.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALU_WB, BRANCH, JUMP or ITYPE_WB. Wraps modulo 2^COUNT_WIDTH.
- The branch input is sampled only in BRANCH; a stale flag in other states has no effect.

Test Plan:
- Reset then opcode=100011 -> states 0,1,2,3,4,0; mem_read high in states 0 and 3; reg_write=1, mem_to_reg=1 in state 4; instr_count=1.
- opcode=000000, funct=100010 -> aluoperation=110 in RTYPE_EX; reg_write=1, reg_dst=1 in ALU_WB; 4 cycles total. Repeat for funct=101010 -> aluoperation=111.
- opcode=000100 with branch=1, then with branch=0 -> BRANCH shows aluoperation=101, pc_source=01, pc_write=1 then 0. opcode=000101 -> aluoperation=011.
- opcode=000010 -> JUMP with pc_write=1, pc_source=10; count advances. opcode=101011 -> mem_write=1 only in state 5, reg_write never asserted.
- opcode=111111 with TRAP_ON_ILLEGAL=1 -> state stays 12 with illegal=1 for 10 cycles, count unchanged; rst -> FETCH, illegal=0. With TRAP_ON_ILLEGAL=0 -> one-cycle illegal pulse, then FETCH.
- Assert rst during MEMRD of a lw -> next cycle state=0, all enables 0, instr_count=0; no reg_write is ever issued for the aborted lw.
